// File: rtl/uart_tx_buffered_pkg.sv
// -----------------------------------------------------------------------------
// uart_defs : shared definitions for the buffered UART transmitter.
//
// Contents
//   tx_state_e         transmitter FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   calc_clks_per_bit  clock cycles per serial bit (integer truncation)
//   calc_cnt_width     width of a counter that must hold 0..clks-1
// -----------------------------------------------------------------------------
package uart_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   function automatic int calc_clks_per_bit(input int clock_frequency, input int baudrate);
      return clock_frequency / baudrate;
   endfunction

   // A counter of at least one bit, even when each bit lasts a single clock.
   function automatic int calc_cnt_width(input int clks);
      return (clks > 1) ? $clog2(clks) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with registered status and registered read.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (pointers, status, read register)
//   wr_en_i     write strobe; accepted only when not full at this edge
//   wr_data_i   data to enqueue
//   rd_en_i     pop strobe; accepted only when not empty at this edge
//   rd_data_o   head entry captured at the pop edge, held until the next pop
//   full_o      registered, level == DEPTH
//   empty_o     registered, level == 0
//   level_o     registered occupancy 0..DEPTH
//   overflow_o  sticky, set by a write attempted while full
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             overflow_q, overflow_d;
   logic             wr_accept;
   logic             rd_accept;

   // Acceptance uses the registered flags, so a pop at the same edge never
   // frees space for a write that arrives while full.
   assign wr_accept = wr_en_i & ~full_q;
   assign rd_accept = rd_en_i & ~empty_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q | (wr_en_i & full_q);
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_accept, rd_accept})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
      full_d  = (level_d == LVL_FULL);
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         if (rd_accept) rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   // Storage has no reset so it maps onto block RAM; resetting the pointers
   // is what discards the contents.
   always_ff @(posedge clk_i) begin
      if (wr_accept) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o  = rd_data_q;
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign level_o    = level_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered : FIFO-buffered 8N1 UART transmitter, LSB first.
//
// Producers write bytes at clock rate; the FSM drains the FIFO one frame at a
// time with exactly one idle-high cycle between consecutive frames.
//
// Ports
//   i_Clock      system clock
//   i_Rst_n      asynchronous active-low reset (aborts any frame, empties FIFO)
//   i_Wr_En      write strobe, one byte per cycle
//   i_Wr_Byte    byte to enqueue
//   o_Full       FIFO holds FIFO_DEPTH entries
//   o_Empty      FIFO holds no entries
//   o_Level      FIFO occupancy
//   o_Overflow   sticky: a write was dropped because the FIFO was full
//   o_Tx_Serial  UART line, idle high, driven from a register
//   o_Tx_Active  high while a frame (start/data/stop) is in progress
//   o_Tx_Done    one-cycle pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
   parameter int CLOCK_FREQUENCY = 48000000,
   parameter int BAUDRATE        = 921600,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                        i_Clock,
   input  logic                        i_Rst_n,
   input  logic                        i_Wr_En,
   input  logic [7:0]                  i_Wr_Byte,
   output logic                        o_Full,
   output logic                        o_Empty,
   output logic [$clog2(FIFO_DEPTH):0] o_Level,
   output logic                        o_Overflow,
   output logic                        o_Tx_Serial,
   output logic                        o_Tx_Active,
   output logic                        o_Tx_Done
);

   import uart_defs::*;

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQUENCY, BAUDRATE);
   localparam int CNT_W        = calc_cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             serial_q, serial_d;
   logic             pop;
   logic             fifo_empty;
   logic [7:0]       shift_data;

   // The FIFO's read register doubles as the frame shift register: it is
   // loaded at the pop edge and stays put until the next pop, which can only
   // happen after this frame returns to IDLE.
   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (i_Clock),
      .rst_ni     (i_Rst_n),
      .wr_en_i    (i_Wr_En),
      .wr_data_i  (i_Wr_Byte),
      .rd_en_i    (pop),
      .rd_data_o  (shift_data),
      .full_o     (o_Full),
      .empty_o    (fifo_empty),
      .level_o    (o_Level),
      .overflow_o (o_Overflow)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is decoded from the next state so the registered output
      // changes on the same edge as the state it belongs to.
      case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_data[idx_d];
         default: serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         serial_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         serial_q <= serial_d;
      end
   end

   assign o_Tx_Serial = serial_q;
   assign o_Empty     = fifo_empty;
   assign o_Tx_Active = (state_q != IDLE);
   assign o_Tx_Done   = (state_q == STOP) && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered : self-checking bench for uart_tx_buffered with
// CLOCK_FREQUENCY=1000, BAUDRATE=100, so every bit lasts 10 clocks.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A line monitor decodes every frame and compares it with a scoreboard queue
// filled whenever the bench drives a byte that the FIFO should accept.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_byte;
   logic       full, empty, overflow, serial, active, done;
   logic [4:0] level;

   always #5 clk = ~clk;

   uart_tx_buffered #(
      .CLOCK_FREQUENCY (1000),
      .BAUDRATE        (100),
      .FIFO_DEPTH      (16)
   ) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Wr_En     (wr_en),
      .i_Wr_Byte   (wr_byte),
      .o_Full      (full),
      .o_Empty     (empty),
      .o_Level     (level),
      .o_Overflow  (overflow),
      .o_Tx_Serial (serial),
      .o_Tx_Active (active),
      .o_Tx_Done   (done)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] sb_q [$];

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop
   } vec_t;
   vec_t vecs [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Present a byte for exactly one rising edge; returns on the falling edge after it.
   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_byte = b;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(seen), 1);
   endtask

   // Single frame from an idle, empty transmitter, checked every cycle.
   task automatic run_frame(input logic [7:0] b, input logic [9:0] fr);
      sb_q.push_back(b);
      write_byte(b);
      check("level_after_write", 32'(level), 1);
      check("empty_after_write", 32'(empty), 0);
      check("serial_before_pop", 32'(serial), 1);
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         check("serial_bit", 32'(serial), 32'(fr[(n-1)/10]));
         check("done_timing", 32'(done), (n == 100) ? 1 : 0);
         if (n == 1) begin
            check("empty_after_pop", 32'(empty), 1);
            check("active_start", 32'(active), 1);
         end
      end
      @(negedge clk);
      check("active_after_frame", 32'(active), 0);
      check("done_after_frame", 32'(done), 0);
      check("serial_idle", 32'(serial), 1);
      $display("frame 0x%02h: sent, checks so far %0d", b, n_checks);
   endtask

   // Line monitor: decodes each frame by mid-bit sampling and scores it on o_Tx_Done.
   bit         in_frame = 1'b0;
   int         mcnt     = 0;
   logic [7:0] mbyte    = 8'h00;
   logic [7:0] mexp;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         check("done_outside_frame", 32'(done), 0);
         if (serial == 1'b0) begin
            in_frame = 1'b1;
            mcnt     = 0;
            mbyte    = 8'h00;
         end
      end else begin
         mcnt++;
         if (mcnt == 5) check("mon_start_bit", 32'(serial), 0);
         if (mcnt >= 15 && mcnt <= 85 && ((mcnt - 15) % 10) == 0)
            mbyte[(mcnt - 15) / 10] = serial;
         if (mcnt == 95) check("mon_stop_bit", 32'(serial), 1);
         if (done) begin
            check("mon_done_offset", 32'(mcnt), 99);
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'(mbyte), 32'hFFFF_FFFF);
            end else begin
               mexp = sb_q.pop_front();
               check("sb_byte", 32'(mbyte), 32'(mexp));
               $display("monitor: byte 0x%02h decoded, expected 0x%02h", mbyte, mexp);
            end
            in_frame = 1'b0;
         end else if (mcnt > 110) begin
            check("mon_frame_length", 32'(mcnt), 99);
            in_frame = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int td [3];

      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_byte = 8'h00;

      vecs[0] = '{8'hA5, 10'h34A};
      vecs[1] = '{8'h3C, 10'h278};
      vecs[2] = '{8'hFF, 10'h3FE};
      vecs[3] = '{8'h00, 10'h200};

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      check("rst_serial", 32'(serial), 1);
      check("rst_active", 32'(active), 0);
      check("rst_done", 32'(done), 0);
      check("rst_full", 32'(full), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_level", 32'(level), 0);
      check("rst_overflow", 32'(overflow), 0);
      $display("reset: state checked");
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // ---------------- single frames from the table ----------------
      for (int v = 0; v < 4; v++) run_frame(vecs[v].data, vecs[v].frame);

      // ---------------- burst of three ----------------
      sb_q.push_back(8'h01);
      sb_q.push_back(8'h02);
      sb_q.push_back(8'h03);
      write_byte(8'h01);
      t0 = cyc;
      write_byte(8'h02);
      write_byte(8'h03);
      check("burst_level", 32'(level), 2);
      for (int k = 0; k < 3; k++) begin
         wait_done(250);
         td[k] = cyc;
      end
      check("burst_first_done", 32'(td[0] - t0), 100);
      check("burst_gap_1", 32'(td[1] - td[0]), 101);
      check("burst_gap_2", 32'(td[2] - td[1]), 101);
      @(negedge clk);
      check("burst_idle_active", 32'(active), 0);
      check("burst_idle_empty", 32'(empty), 1);
      $display("burst: three frames, done gaps %0d %0d", td[1] - td[0], td[2] - td[1]);

      // ---------------- overflow: 20 writes from empty ----------------
      for (int i = 0; i < 20; i++) begin
         // The first byte is popped at the second edge; the rest pile up,
         // so exactly writes 0..16 fit into 16 entries.
         if (i <= 16) sb_q.push_back(8'(i));
         write_byte(8'(i));
         check("ovf_level", 32'(level), (i == 0) ? 1 : ((i <= 16) ? i : 16));
         if (i == 15) check("ovf_full_15", 32'(full), 0);
         if (i == 16) begin
            check("ovf_full_16", 32'(full), 1);
            check("ovf_flag_16", 32'(overflow), 0);
         end
         if (i == 17) check("ovf_flag_17", 32'(overflow), 1);
      end
      $display("overflow: 20 writes issued, level %0d overflow %0d", level, overflow);

      // ---------------- drain ----------------
      for (int k = 1; k <= 17; k++) begin
         wait_done(250);
         check("drain_level", 32'(level), 17 - k);
      end
      @(negedge clk);
      check("drain_empty", 32'(empty), 1);
      check("drain_active", 32'(active), 0);
      check("drain_sb_empty", 32'(sb_q.size()), 0);
      $display("drain: 17 frames completed");

      // ---------------- reset in the middle of a frame ----------------
      sb_q.push_back(8'hC3);
      sb_q.push_back(8'h77);
      sb_q.push_back(8'h11);
      write_byte(8'hC3);
      write_byte(8'h77);
      write_byte(8'h11);
      repeat (43) @(negedge clk);          // falling edge after edge 45: data bit 3
      check("pre_reset_serial", 32'(serial), 0);
      check("pre_reset_level", 32'(level), 2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_serial", 32'(serial), 1);
      check("async_rst_level", 32'(level), 0);
      check("async_rst_active", 32'(active), 0);
      check("async_rst_empty", 32'(empty), 1);
      check("async_rst_overflow", 32'(overflow), 0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      $display("reset mid-frame: line and FIFO cleared");
      run_frame(8'h5A, 10'h2B4);

      // ---------------- full FIFO with a write at the pop edge ----------------
      for (int i = 0; i <= 16; i++) begin
         sb_q.push_back(8'(8'h80 + i));
         write_byte(8'(8'h80 + i));
      end
      check("fp_level_full", 32'(level), 16);
      check("fp_full", 32'(full), 1);
      wait_done(250);
      @(negedge clk);                      // idle cycle; the pop edge is next
      check("fp_idle_active", 32'(active), 0);
      check("fp_idle_level", 32'(level), 16);
      check("fp_idle_overflow", 32'(overflow), 0);
      wr_en   = 1'b1;
      wr_byte = 8'hEE;                     // must be dropped, not scored
      @(negedge clk);
      wr_en   = 1'b0;
      check("fp_overflow", 32'(overflow), 1);
      check("fp_level_after", 32'(level), 15);
      check("fp_full_after", 32'(full), 0);
      check("fp_active_after", 32'(active), 1);
      $display("full+pop: write at pop edge dropped, level %0d", level);
      for (int k = 0; k < 16; k++) wait_done(250);
      @(negedge clk);
      check("fp_final_empty", 32'(empty), 1);
      check("fp_final_active", 32'(active), 0);
      check("fp_sb_empty", 32'(sb_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
